sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_sample_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_feeder.sv
// sample_feeder: streams waveform ROM words as (current, next) sample pairs
// for an interpolator, with a new pair presented every 10^Mode clock cycles.
// Latency: first Enable on the 4th rising edge after Run rises (E0..E3);
// after that, one Enable every P = 10^min(Mode,MODE_MAX) cycles.
// Backpressure: none. Run=0 stops on the next edge, holds out1/out2/rom_addr
// and suppresses any Enable due on that edge.
//
// Ports:
//   Fg_CLK, RESETn  - clock (rising edge) and asynchronous active-low reset
//   Run             - level; 1 generates samples, 0 returns to IDLE
//   freq_word       - phase increment per sample, sampled at every advance
//   Mode            - period exponent; latched at each Enable
//   rom_addr        - registered ROM address (phase MSBs)
//   rom_data        - ROM word, valid 2 edges after rom_addr changes
//   out2 / out1     - current sample s_j / next sample s_j+1
//   Enable          - one-cycle strobe marking a new out1/out2 pair
//   Busy            - high whenever the FSM is not in IDLE
module sample_feeder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MODE_MAX = 5
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Run,
  input  logic [31:0]       freq_word,
  input  logic [3:0]        Mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out1,
  output logic              Enable,
  output logic              Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [3:0] MODE_CAP = (MODE_MAX > 15) ? 4'd15 : 4'(MODE_MAX);

  // Period minus one for a given exponent; anything above 9 saturates.
  function automatic logic [31:0] f_last(input logic [3:0] m);
    case (m)
      4'd0:    f_last = 32'd0;
      4'd1:    f_last = 32'd9;
      4'd2:    f_last = 32'd99;
      4'd3:    f_last = 32'd999;
      4'd4:    f_last = 32'd9999;
      4'd5:    f_last = 32'd99999;
      4'd6:    f_last = 32'd999999;
      4'd7:    f_last = 32'd9999999;
      4'd8:    f_last = 32'd99999999;
      default: f_last = 32'd999999999;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_phase;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_out1;
  logic [DATA_W-1:0]   r_out2;
  logic                r_en;
  logic [31:0]         r_cnt;
  logic [3:0]          r_mode;
  logic [1:0]          r_fcnt;

  // Address-change history: r_a2 set means rom_data now carries the word
  // for an address driven two edges ago, i.e. a fresh sample.
  logic                r_a1;
  logic                r_a2;

  // Two-entry holding queue for fresh ROM words. During FILL the address
  // moves every cycle, but in RUN with P>1 the words arrive long before
  // they are consumed, so up to two of them (s_j+2, s_j+3) wait here.
  logic [DATA_W-1:0]   r_q0;
  logic [DATA_W-1:0]   r_q1;
  logic [1:0]          r_qn;

  logic                w_start;
  logic                w_adv;
  logic                w_fire;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_head;
  logic [31:0]         w_last;
  logic [3:0]          w_mode_eff;

  assign w_last     = f_last(r_mode);
  assign w_mode_eff = (Mode > MODE_CAP) ? MODE_CAP : Mode;
  assign w_push     = r_a2 && (r_state != ST_IDLE);
  assign w_pop      = w_adv && ((r_qn != 2'd0) || w_push);
  // An empty queue bypasses the incoming word straight to out1.
  assign w_head     = (r_qn == 2'd0) ? rom_data : r_q0;

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Run) begin
          w_start     = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!Run) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_adv = 1'b1;
          // Third fill advance (E3) completes the three-sample lead.
          if (r_fcnt == 2'd2) begin
            w_fire      = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Stop wins over a due Enable.
        if (!Run) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == w_last) begin
          w_adv  = 1'b1;
          w_fire = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_phase <= 32'd0;
      r_addr  <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_en    <= 1'b0;
      r_cnt   <= 32'd0;
      r_mode  <= 4'd0;
      r_fcnt  <= 2'd0;
      r_a1    <= 1'b0;
      r_a2    <= 1'b0;
      r_q0    <= '0;
      r_q1    <= '0;
      r_qn    <= 2'd0;
    end else begin
      r_en <= w_fire;
      r_a1 <= w_start || w_adv;
      r_a2 <= r_a1;

      if (w_start) begin
        r_phase <= freq_word;
        r_addr  <= '0;
        r_fcnt  <= 2'd0;
        r_cnt   <= 32'd0;
      end else if (w_adv) begin
        r_out2  <= r_out1;
        r_out1  <= w_head;
        r_phase <= r_phase + freq_word;
        r_addr  <= r_phase[31:32-ADDR_W];
        if (r_state == ST_FILL) r_fcnt <= r_fcnt + 2'd1;
      end

      if (w_fire) begin
        r_cnt  <= 32'd0;
        r_mode <= w_mode_eff;
      end else if (r_state == ST_RUN && Run) begin
        r_cnt <= r_cnt + 32'd1;
      end

      if (w_start) begin
        r_qn <= 2'd0;
      end else begin
        case (r_qn)
          2'd0: begin
            if (w_push && !w_pop) begin
              r_q0 <= rom_data;
              r_qn <= 2'd1;
            end
          end
          2'd1: begin
            if (w_push && w_pop) begin
              r_q0 <= rom_data;
            end else if (w_push) begin
              r_q1 <= rom_data;
              r_qn <= 2'd2;
            end else if (w_pop) begin
              r_qn <= 2'd0;
            end
          end
          default: begin
            if (w_pop) begin
              r_q0 <= r_q1;
              if (w_push) r_q1 <= rom_data;
              else        r_qn <= 2'd1;
            end
          end
        endcase
      end
    end
  end

  assign rom_addr = r_addr;
  assign out1     = r_out1;
  assign out2     = r_out2;
  assign Enable   = r_en;
  assign Busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

  logic        clk;
  logic        RESETn;
  logic        Run;
  logic [31:0] freq_word;
  logic [3:0]  Mode;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] out2;
  logic [31:0] out1;
  logic        Enable;
  logic        Busy;

  logic [31:0] rom [1024];
  logic [31:0] rom_q;

  typedef struct {
    logic [31:0] o2;
    logic [31:0] o1;
    logic [9:0]  addr;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   t_last;

  // MODE_MAX lowered so that a clamped Mode=9 gives a 1000-cycle period.
  sample_feeder #(.ADDR_W(10), .DATA_W(32), .MODE_MAX(3)) dut (
    .Fg_CLK    (clk),
    .RESETn    (RESETn),
    .Run       (Run),
    .freq_word (freq_word),
    .Mode      (Mode),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out2      (out2),
    .out1      (out1),
    .Enable    (Enable),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: latches the address on the edge after it changes.
  always @(posedge clk) rom_q <= rom[rom_addr];
  assign rom_data = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] samp(input int idx);
    samp = 32'(1000 * (idx % 1024));
  endfunction

  // Pair n of a run: out2=s_n, out1=s_n+1, rom_addr three samples ahead.
  task automatic push_one(input int idx, input int gap);
    exp_t e;
    e.o2   = samp(idx);
    e.o1   = samp(idx + 1);
    e.addr = 10'((idx + 3) % 1024);
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (Enable === 1'b1) begin
        checks++;
        assert (sb.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_enable: observed Enable at cycle %0d expected none", cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out2", out2, e.o2);
          chk("out1", out1, e.o1);
          chk("rom_addr_lead", 32'(rom_addr), 32'(e.addr));
          chk("enable_gap", 32'(cyc - t_last), 32'(e.gap));
          t_last = cyc;
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    t_last    = 0;
    RESETn    = 1'b0;
    Run       = 1'b0;
    freq_word = 32'h0040_0000;
    Mode      = 4'd1;
    for (int i = 0; i < 1024; i++) rom[i] = 32'(1000 * i);

    #12;
    chk("rst_out1", out1, 32'd0);
    chk("rst_out2", out2, 32'd0);
    chk("rst_enable", 32'(Enable), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    tick(2);
    RESETn = 1'b1;
    tick(2);
    chk("idle_busy", 32'(Busy), 32'd0);

    // Basic start, Mode=1; stop lands on the edge where Enable is due.
    Mode = 4'd1;
    Run  = 1'b1;
    t_last = cyc;
    push_one(0, 4);
    push_one(1, 10);
    push_one(2, 10);
    tick(24);
    chk("run_busy", 32'(Busy), 32'd1);
    tick(9);
    Run = 1'b0;
    tick(1);
    chk("stop_busy", 32'(Busy), 32'd0);
    chk("stop_enable", 32'(Enable), 32'd0);
    chk("stop_out2_hold", out2, 32'd2000);
    chk("stop_out1_hold", out1, 32'd3000);
    chk("stop_addr_hold", 32'(rom_addr), 32'd5);
    tick(3);
    chk("idle_out1_hold", out1, 32'd3000);

    // Mode 0 through the 1023->0 address wrap, then stop mid-stream.
    Mode = 4'd0;
    Run  = 1'b1;
    t_last = cyc;
    for (int i = 0; i < 1027; i++) push_one(i, (i == 0) ? 4 : 1);
    tick(1030);
    Run = 1'b0;
    tick(1);
    chk("m0_stop_busy", 32'(Busy), 32'd0);
    chk("m0_stop_out2", out2, 32'd2000);
    chk("m0_stop_out1", out1, 32'd3000);
    chk("m0_stop_addr", 32'(rom_addr), 32'd5);

    // Mode clamp: 9 saturates to MODE_MAX=3.
    Mode = 4'd9;
    Run  = 1'b1;
    t_last = cyc;
    push_one(0, 4);
    push_one(1, 1000);
    tick(1004);
    Run = 1'b0;
    tick(2);

    // Mode 1->2 mid-period: current gap stays 10, following gaps are 100.
    Mode = 4'd1;
    Run  = 1'b1;
    t_last = cyc;
    push_one(0, 4);
    push_one(1, 10);
    push_one(2, 100);
    push_one(3, 100);
    tick(7);
    Mode = 4'd2;
    tick(207);
    Run = 1'b0;
    tick(1);

    // Reset mid-RUN, then restart with Run held high.
    Mode = 4'd1;
    Run  = 1'b1;
    t_last = cyc;
    push_one(0, 4);
    push_one(1, 10);
    tick(17);
    RESETn = 1'b0;
    #1;
    chk("mid_rst_out1", out1, 32'd0);
    chk("mid_rst_out2", out2, 32'd0);
    chk("mid_rst_enable", 32'(Enable), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    tick(2);
    RESETn = 1'b1;
    t_last = cyc;
    push_one(0, 4);
    push_one(1, 10);
    push_one(2, 10);
    tick(24);

    chk("pending_pairs", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
